mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between two requesters: the fetch unit (I-port) and the memory-access stage (D-port).
- Registers the winning request onto one memory handshake and returns the response to the owner.
- Provides stall inputs to the fetch/pipeline-register logic and discards fetch responses killed by a branch/jalr flush.
- Sits between the fetch and memory-access stages and the memory model, under the core top.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared configuration for the unified-memory port arbiter: the default
//   data/address width, the default D-burst limit, and the arbiter state
//   encoding.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Default data/address width of the core.
  localparam int ARB_XLEN = 32;

  // Default number of consecutive D grants allowed while a fetch is waiting.
  localparam int ARB_MAX_D_BURST = 4;

  // Arbiter ownership state.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares a single-ported unified instruction/data memory between the fetch
//   unit (I-port) and the memory-access stage (D-port). The winning request is
//   registered onto one memory handshake (one cycle of arbitration latency)
//   and the memory response is routed combinationally back to its owner.
//   D normally wins; a saturating counter forces a waiting fetch through after
//   MAX_D_BURST consecutive D grants. Fetches killed by a flush still complete
//   on the memory side but their response is suppressed.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ready or if_kill)
//   if_kill             flush pulse, cancels any outstanding fetch
//   if_ready/if_rdata   one-cycle fetch completion with instruction
//   d_req/d_we/d_wstrb/d_addr/d_wdata
//                       load/store request (held until d_ready)
//   d_ready/d_rdata     one-cycle data completion with load data
//   m_req/m_we/m_wstrb/m_addr/m_wdata
//                       registered memory request, held until m_ack
//   m_ack/m_rdata       memory completion pulse with read data
//   stall_if/stall_mem  stall requests to the fetch / memory stage
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN        = ARB_XLEN,
  parameter int MAX_D_BURST = ARB_MAX_D_BURST
) (
  input  logic            clk,
  input  logic            rst,
  // fetch port
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_ready,
  output logic [XLEN-1:0] if_rdata,
  // data port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [3:0]      d_wstrb,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  // memory port
  output logic            m_req,
  output logic            m_we,
  output logic [3:0]      m_wstrb,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata,
  // stalls
  output logic            stall_if,
  output logic            stall_mem
);

  // Counter wide enough to hold MAX_D_BURST itself (the saturation value).
  localparam int               CNT_W   = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             kill_q;
  logic             m_req_q;
  logic             m_we_q;
  logic [3:0]       m_wstrb_q;
  logic [XLEN-1:0]  m_addr_q;
  logic [XLEN-1:0]  m_wdata_q;

  // Arbitration decision used only while idle. D has priority unless a fetch
  // has already waited through MAX_D_BURST D grants. A flush in the same
  // cycle blocks an I grant, since the fetch address is about to change.
  logic i_starved;
  logic sel_d;
  logic sel_i;

  assign i_starved = if_req & (cnt_q == CNT_MAX);
  assign sel_d     = d_req & ~i_starved;
  assign sel_i     = ~sel_d & if_req & ~if_kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_wstrb_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          // m_ack here is a stray pulse and is deliberately ignored.
          if (sel_d) begin
            state_q   <= ARB_GNT_D;
            m_req_q   <= 1'b1;
            m_we_q    <= d_we;
            m_wstrb_q <= d_wstrb;
            m_addr_q  <= d_addr;
            m_wdata_q <= d_wdata;
            // Only D grants that make a fetch wait count toward starvation.
            if (if_req) begin
              if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else begin
              cnt_q <= '0;
            end
          end else if (sel_i) begin
            state_q   <= ARB_GNT_I;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_wstrb_q <= '0;
            m_addr_q  <= if_addr;
            m_wdata_q <= '0;
            cnt_q     <= '0;
          end
        end

        ARB_GNT_I: begin
          // A flushed fetch still runs to completion on the memory side so
          // the handshake is never withdrawn; only the response is dropped.
          if (if_kill) begin
            kill_q <= 1'b1;
          end
          if (m_ack) begin
            m_req_q <= 1'b0;
            kill_q  <= 1'b0;
            state_q <= ARB_IDLE;
          end
        end

        ARB_GNT_D: begin
          if (m_ack) begin
            m_req_q <= 1'b0;
            state_q <= ARB_IDLE;
          end
        end

        default: begin
          m_req_q <= 1'b0;
          kill_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_wstrb = m_wstrb_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  // Responses go straight back to the owner in the ack cycle. A kill seen in
  // the ack cycle itself must also suppress the fetch response.
  assign d_ready  = (state_q == ARB_GNT_D) & m_ack;
  assign if_ready = (state_q == ARB_GNT_I) & m_ack & ~kill_q & ~if_kill;
  assign d_rdata  = m_rdata;
  assign if_rdata = m_rdata;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios followed by a randomized run against a transaction-
//   level reference model (request queues, a word-array memory and a D-streak
//   count).
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_kill;
  logic            if_ready;
  logic [XLEN-1:0] if_rdata;
  logic            d_req;
  logic            d_we;
  logic [3:0]      d_wstrb;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ready;
  logic [XLEN-1:0] d_rdata;
  logic            m_req;
  logic            m_we;
  logic [3:0]      m_wstrb;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic            m_ack;
  logic [XLEN-1:0] m_rdata;
  logic            stall_if;
  logic            stall_mem;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = 0; if_kill = 0;
    d_req = 0; d_we = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
    m_ack = 0; m_rdata = 0;
    @(negedge clk); @(negedge clk);
    checks++; if ({m_req, m_we, m_wstrb} !== 6'b0) begin errors++;
      $display("FAIL reset_mreq got=%b req=000000", {m_req, m_we, m_wstrb}); end
    checks++; if ({m_addr, m_wdata} !== 64'b0) begin errors++;
      $display("FAIL reset_maddr got=%h req=0", {m_addr, m_wdata}); end
    checks++; if ({if_ready, d_ready, stall_if, stall_mem} !== 4'b0) begin errors++;
      $display("FAIL reset_ready got=%b req=0000", {if_ready, d_ready, stall_if, stall_mem}); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_lone_fetch();
    @(negedge clk); if_req = 1; if_addr = 32'h100; #1;
    checks++; if ({m_req, stall_if} !== 2'b01) begin errors++;
      $display("FAIL fetch_c0 m_req,stall_if got=%b req=01", {m_req, stall_if}); end
    @(negedge clk); #1;
    checks++; if ({m_req, m_we, stall_if, if_ready} !== 4'b1010 || m_addr !== 32'h100) begin errors++;
      $display("FAIL fetch_c1 got=%b addr=%h req=1010 addr=100", {m_req, m_we, stall_if, if_ready}, m_addr); end
    @(negedge clk); m_ack = 1; m_rdata = 32'h00500093; #1;
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h00500093 || stall_if !== 1'b0 || d_ready !== 1'b0) begin errors++;
      $display("FAIL fetch_c2 rdy=%b data=%h stall=%b req rdy=1 data=00500093 stall=0", if_ready, if_rdata, stall_if); end
    @(negedge clk); m_ack = 0; if_req = 0; #1;
    checks++; if ({m_req, if_ready} !== 2'b00) begin errors++;
      $display("FAIL fetch_c3 got=%b req=00", {m_req, if_ready}); end
    $display("test_lone_fetch done");
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_wstrb = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    @(negedge clk); #1;
    checks++; if ({m_req, m_we, m_wstrb} !== 6'b111111 || m_addr !== 32'h2000 || m_wdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL simul_dgrant got=%b addr=%h wd=%h req=111111 2000 DEADBEEF", {m_req, m_we, m_wstrb}, m_addr, m_wdata); end
    m_ack = 1; #1;
    checks++; if ({d_ready, if_ready, stall_mem, stall_if} !== 4'b1001) begin errors++;
      $display("FAIL simul_dready got=%b req=1001", {d_ready, if_ready, stall_mem, stall_if}); end
    @(negedge clk); m_ack = 0; d_req = 0; #1;
    checks++; if (m_req !== 1'b0) begin errors++;
      $display("FAIL simul_idle m_req got=%b req=0", m_req); end
    @(negedge clk); #1;
    checks++; if ({m_req, m_we} !== 2'b10 || m_addr !== 32'h104) begin errors++;
      $display("FAIL simul_igrant got=%b addr=%h req=10 104", {m_req, m_we}, m_addr); end
    m_ack = 1; m_rdata = 32'h12345678; #1;
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h12345678) begin errors++;
      $display("FAIL simul_iready got=%b %h req=1 12345678", if_ready, if_rdata); end
    @(negedge clk); m_ack = 0; if_req = 0; d_we = 0; d_wstrb = 0;
    $display("test_simultaneous done");
  endtask

  task automatic test_burst();
    bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit found;
    bit is_d;
    @(negedge clk);
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_wstrb = 0; d_addr = 32'h1000;
    for (int g = 0; g < 6; g++) begin
      found = 0;
      for (int w = 0; w < 8 && !found; w++) begin
        @(negedge clk); #1;
        if (m_req === 1'b1) found = 1;
      end
      checks++;
      if (!found) begin errors++;
        $display("FAIL burst_timeout grant=%0d got=no_grant req=grant", g);
        break;
      end
      is_d = (m_addr !== 32'h300);
      checks++; if (is_d !== exp_d[g]) begin errors++;
        $display("FAIL burst_order grant=%0d got_is_d=%0b req_is_d=%0b", g, is_d, exp_d[g]); end
      m_ack = 1; m_rdata = 32'hA000_0000 + g; #1;
      checks++; if ({d_ready, if_ready} !== (is_d ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL burst_ready grant=%0d got=%b req=%b", g, {d_ready, if_ready}, is_d ? 2'b10 : 2'b01); end
      @(negedge clk); m_ack = 0;
      if (is_d) begin d_addr = d_addr + 4; if (g == 5) d_req = 0; end
      else if_req = 0;
    end
    d_req = 0; if_req = 0; m_ack = 0;
    $display("test_burst done");
  endtask

  task automatic test_kill();
    // Kill while idle blocks the grant for that cycle only.
    @(negedge clk); if_req = 1; if_addr = 32'h180; if_kill = 1;
    @(negedge clk); if_kill = 0; #1;
    checks++; if (m_req !== 1'b0) begin errors++;
      $display("FAIL kill_idle m_req got=%b req=0", m_req); end
    @(negedge clk); if_kill = 1; #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h180 || if_ready !== 1'b0) begin errors++;
      $display("FAIL kill_grant got=%b %h req=1 180", m_req, m_addr); end
    @(negedge clk); if_kill = 0; if_addr = 32'h200; #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h180) begin errors++;
      $display("FAIL kill_hold got=%b %h req=1 180", m_req, m_addr); end
    @(negedge clk); #1;
    @(negedge clk); m_ack = 1; m_rdata = 32'hBAD0BAD0; #1;
    checks++; if (if_ready !== 1'b0 || stall_if !== 1'b1) begin errors++;
      $display("FAIL kill_suppress rdy=%b stall=%b req rdy=0 stall=1", if_ready, stall_if); end
    @(negedge clk); m_ack = 0; #1;
    checks++; if (m_req !== 1'b0) begin errors++;
      $display("FAIL kill_release m_req got=%b req=0", m_req); end
    @(negedge clk); #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h200) begin errors++;
      $display("FAIL kill_next got=%b %h req=1 200", m_req, m_addr); end
    m_ack = 1; m_rdata = 32'h00000013; #1;
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h00000013) begin errors++;
      $display("FAIL kill_next_ready got=%b %h req=1 00000013", if_ready, if_rdata); end
    @(negedge clk); m_ack = 0; if_req = 0;
    $display("test_kill done");
  endtask

  task automatic test_async_reset();
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h40;
    @(negedge clk); #1;
    checks++; if (m_req !== 1'b1) begin errors++;
      $display("FAIL areset_pre m_req got=%b req=1", m_req); end
    #2; rst = 1; m_ack = 1; #1;
    checks++; if (m_req !== 1'b0 || m_addr !== 32'h0 || d_ready !== 1'b0) begin errors++;
      $display("FAIL areset_now m_req=%b addr=%h d_ready=%b req 0 0 0", m_req, m_addr, d_ready); end
    d_req = 0; m_ack = 0;
    @(negedge clk); rst = 0;
    @(negedge clk); #1;
    checks++; if (m_req !== 1'b0) begin errors++;
      $display("FAIL areset_after m_req got=%b req=0", m_req); end
    $display("test_async_reset done");
  endtask

  task automatic test_spurious_ack();
    @(negedge clk); m_ack = 1; #1;
    checks++; if ({m_req, if_ready, d_ready} !== 3'b000) begin errors++;
      $display("FAIL spurious_idle got=%b req=000", {m_req, if_ready, d_ready}); end
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h80; #1;
    checks++; if (d_ready !== 1'b0 || stall_mem !== 1'b1) begin errors++;
      $display("FAIL spurious_with_req d_ready=%b stall=%b req 0 1", d_ready, stall_mem); end
    @(negedge clk); m_ack = 0; #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'h80) begin errors++;
      $display("FAIL spurious_then_grant got=%b %h req=1 80", m_req, m_addr); end
    m_ack = 1; m_rdata = 32'h5555AAAA; #1;
    checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h5555AAAA) begin errors++;
      $display("FAIL spurious_load got=%b %h req=1 5555AAAA", d_ready, d_rdata); end
    @(negedge clk); m_ack = 0; d_req = 0;
    $display("test_spurious_ack done");
  endtask

  task automatic test_random(input int ncyc);
    logic [31:0] tmem [64];
    bit busy = 0, own_d = 0, killed = 0;
    int wait_n = 0, streak = 0;
    logic [31:0] o_addr = 0, o_wd = 0;
    logic [3:0]  o_strb = 0;
    bit o_we = 0;
    bit i_done = 0, d_done = 0;
    bit exp_ir, exp_dr;
    int n_i = 0, n_d = 0, n_k = 0;
    for (int i = 0; i < 64; i++) tmem[i] = $urandom;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      // requesters: hold until done, then drop or issue a new request
      if (if_req && i_done) if_req = 0;
      if (!if_req && $urandom_range(0, 1) == 0) begin
        if_req = 1; if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if_kill = if_req && ($urandom_range(0, 11) == 0);
      if (d_req && d_done) d_req = 0;
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_wstrb = d_we ? 4'($urandom_range(1, 15)) : 4'h0;
        d_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; d_wdata = $urandom;
      end
      // memory model
      m_ack = 0;
      if (busy) begin
        if (wait_n == 0) m_ack = 1; else wait_n--;
      end else begin
        m_ack = ($urandom_range(0, 15) == 0);
      end
      m_rdata = tmem[m_addr[7:2]];
      #1;
      exp_dr = busy && own_d && m_ack;
      exp_ir = busy && !own_d && m_ack && !killed && !if_kill;
      checks++; if (m_req !== busy) begin errors++;
        $display("FAIL rnd_m_req cyc=%0d got=%b req=%b", t, m_req, busy); end
      if (busy) begin
        checks++; if (m_addr !== o_addr || m_we !== o_we || m_wstrb !== o_strb || (o_we && m_wdata !== o_wd)) begin errors++;
          $display("FAIL rnd_mfields cyc=%0d got=%h %b %h %h req=%h %b %h %h", t, m_addr, m_we, m_wstrb, m_wdata, o_addr, o_we, o_strb, o_wd); end
      end
      checks++; if (d_ready !== exp_dr || if_ready !== exp_ir) begin errors++;
        $display("FAIL rnd_ready cyc=%0d got d=%b i=%b req d=%b i=%b", t, d_ready, if_ready, exp_dr, exp_ir); end
      if (exp_ir) begin
        checks++; if (if_rdata !== tmem[o_addr[7:2]]) begin errors++;
          $display("FAIL rnd_if_rdata cyc=%0d got=%h req=%h", t, if_rdata, tmem[o_addr[7:2]]); end
      end
      if (exp_dr && !o_we) begin
        checks++; if (d_rdata !== tmem[o_addr[7:2]]) begin errors++;
          $display("FAIL rnd_d_rdata cyc=%0d got=%h req=%h", t, d_rdata, tmem[o_addr[7:2]]); end
      end
      checks++; if (stall_if !== (if_req && !exp_ir) || stall_mem !== (d_req && !exp_dr)) begin errors++;
        $display("FAIL rnd_stall cyc=%0d got if=%b mem=%b req if=%b mem=%b", t, stall_if, stall_mem, if_req && !exp_ir, d_req && !exp_dr); end
      // what happens at the coming clock edge
      i_done = exp_ir || if_kill;
      d_done = exp_dr;
      if (busy) begin
        if (!own_d && if_kill) killed = 1;
        if (m_ack) begin
          if (o_we) for (int b = 0; b < 4; b++) if (o_strb[b]) tmem[o_addr[7:2]][8*b +: 8] = o_wd[8*b +: 8];
          if (!own_d && killed) n_k++;
          busy = 0; killed = 0;
        end
      end else if (d_req && !(if_req && streak == MAXB)) begin
        busy = 1; own_d = 1; o_addr = d_addr; o_we = d_we; o_strb = d_wstrb; o_wd = d_wdata;
        streak = if_req ? ((streak < MAXB) ? streak + 1 : MAXB) : 0;
        wait_n = $urandom_range(0, 3); n_d++;
      end else if (if_req && !if_kill) begin
        busy = 1; own_d = 0; o_addr = if_addr; o_we = 0; o_strb = 0; o_wd = 0;
        streak = 0; wait_n = $urandom_range(0, 3); n_i++;
      end
    end
    @(negedge clk); if_req = 0; d_req = 0; if_kill = 0; m_ack = 0;
    $display("test_random done: %0d I grants, %0d D grants, %0d killed fetches", n_i, n_d, n_k);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_burst();
    test_kill();
    test_async_reset();
    test_spurious_ack();
    test_random(4000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
